// File: rtl/req_initiator.sv
// req_initiator: req/gnt handshake initiator with per-attempt timeout, backoff and bounded retry.
// Define REQ_INITIATOR_ASSERT_EN to compile the embedded SVA checks and covers.
module req_initiator #(
  parameter int TIMEOUT   = 4,
  parameter int BACKOFF   = 2,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             gnt,
  output logic             req,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       attempt,
  output logic [CNT_W-1:0] grant_cnt,
  output logic             stray_gnt
);
  localparam logic [7:0] L_TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] L_BO_LAST = 8'(BACKOFF - 1);
  localparam logic [3:0] L_MAX     = 4'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_BACKOFF, S_DONE, S_ERR} state_t;

  state_t     r_state, w_next;
  logic [7:0] r_wait, r_bo, w_wait_nxt, w_bo_nxt;
  logic [3:0] w_attempt_nxt;

  always_comb begin
    w_next        = r_state;
    w_wait_nxt    = r_wait;
    w_bo_nxt      = r_bo;
    w_attempt_nxt = attempt;
    case (r_state)
      S_IDLE: if (start) begin
        w_next        = S_REQ;
        w_attempt_nxt = 4'd1;
        w_wait_nxt    = 8'd0;
      end
      // a grant on the timeout boundary still wins
      S_REQ: if (gnt) w_next = S_DONE;
        else if (r_wait == L_TO_LAST) begin
          w_next   = (attempt == L_MAX) ? S_ERR : S_BACKOFF;
          w_bo_nxt = 8'd0;
        end else w_wait_nxt = r_wait + 8'd1;
      S_BACKOFF: if (r_bo == L_BO_LAST) begin
        w_next        = S_REQ;
        w_attempt_nxt = attempt + 4'd1;
        w_wait_nxt    = 8'd0;
      end else w_bo_nxt = r_bo + 8'd1;
      default: w_next = S_IDLE;
    endcase
  end

  // outputs are registered from the next state so they track the state exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_bo      <= '0;
      req       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      attempt   <= '0;
      grant_cnt <= '0;
      stray_gnt <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
      r_bo    <= w_bo_nxt;
      req     <= w_next == S_REQ;
      busy    <= w_next != S_IDLE;
      done    <= w_next == S_DONE;
      err     <= w_next == S_ERR;
      attempt <= w_attempt_nxt;
      if (w_next == S_DONE && grant_cnt != '1) grant_cnt <= grant_cnt + 1'b1;
      if (gnt && r_state != S_REQ) stray_gnt <= 1'b1;
    end
  end

`ifdef REQ_INITIATOR_ASSERT_EN
  a_req_hold: assert property (@(posedge clk) disable iff (reset)
    $rose(req) |-> (req [*TIMEOUT]) or (req [*1:TIMEOUT] ##0 gnt));
  a_done_err_excl: assert property (@(posedge clk) disable iff (reset) !(done && err));
  a_result_busy: assert property (@(posedge clk) disable iff (reset) (done || err) |-> $past(busy));
  a_req_busy: assert property (@(posedge clk) disable iff (reset) !busy |-> !req);
  c_lat_min: cover property (@(posedge clk) disable iff (reset) $rose(req) ##0 gnt);
  c_lat_max: cover property (@(posedge clk) disable iff (reset)
    $rose(req) ##0 (req && !gnt) [*TIMEOUT-1] ##1 (req && gnt));
`else
`endif
endmodule

// File: tb/tb_req_initiator.sv
// tb_req_initiator: scoreboard bench for req_initiator with a per-transaction grant responder.
module tb_req_initiator;
  localparam int TIMEOUT = 4, BACKOFF = 2, MAX_RETRY = 3, CNT_W = 8;

  logic             clk, reset, start, gnt;
  logic             req, busy, done, err, stray_gnt;
  logic [3:0]       attempt;
  logic [CNT_W-1:0] grant_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  typedef struct {logic is_done; logic [3:0] att; logic [7:0] cnt;} exp_t;
  exp_t sb_q[$];

  req_initiator #(.TIMEOUT(TIMEOUT), .BACKOFF(BACKOFF), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .gnt(gnt), .req(req), .busy(busy), .done(done),
    .err(err), .attempt(attempt), .grant_cnt(grant_cnt), .stray_gnt(stray_gnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // g = attempt that gets granted (0: never), lat = grant latency, extra = second start during REQ
  task automatic run_txn(input int g, input int lat, input bit extra);
    exp_t e;
    int   c, gap, att, cyc, n_extra;
    bit   prev_req, fin;
    e.is_done = (g >= 1 && g <= MAX_RETRY);
    e.att     = e.is_done ? 4'(g) : 4'(MAX_RETRY);
    if (e.is_done && exp_cnt != 255) exp_cnt++;
    e.cnt = 8'(exp_cnt);
    sb_q.push_back(e);
    check("busy_before", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0; gap = 0; att = 0; cyc = 0; prev_req = 0; fin = 0;
    while (!fin && cyc < 100) begin
      if (req && !prev_req) begin
        att++;
        if (att > 1) check("backoff_gap", gap, BACKOFF);
        c = 0;
      end
      if (req) c++;
      if (!req && prev_req && !done) begin
        check("req_len", c, TIMEOUT);
        gap = 1;
      end else if (!req) gap++;
      if (done || err) begin
        check("done_err_excl", done && err, 0);
        if (done) check("grant_lat", c, lat);
        if (sb_q.size() == 0) check("sb_empty", 1, 0);
        else begin
          e = sb_q.pop_front();
          check("is_done", done, e.is_done);
          check("is_err", err, !e.is_done);
          check("attempt", attempt, e.att);
          check("grant_cnt", grant_cnt, e.cnt);
        end
        fin = 1;
      end
      start = (extra && att == 1 && c == 1) ? 1'b1 : 1'b0;
      gnt   = (req && att == g && c == lat) ? 1'b1 : 1'b0;
      prev_req = req;
      cyc++;
      tick();
    end
    start = 1'b0;
    gnt   = 1'b0;
    if (!fin) check("txn_timeout", 0, 1);
    check("busy_after", busy, 0);
    check("req_after", req, 0);
    if (extra) begin
      n_extra = 0;
      for (int i = 0; i < 10; i++) begin
        if (done || req) n_extra++;
        tick();
      end
      check("extra_start_ignored", n_extra, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; gnt = 1'b0;
    #12;
    check("rst_req", req, 0);
    check("rst_busy", busy, 0);
    check("rst_attempt", attempt, 0);
    check("rst_cnt", grant_cnt, 0);
    check("rst_stray", stray_gnt, 0);
    #8 reset = 1'b0;
    tick();
    run_txn(1, 2, 0);
    run_txn(0, 0, 0);
    run_txn(2, 4, 0);
    run_txn(3, 1, 0);
    run_txn(1, 4, 0);
    check("stray_clear", stray_gnt, 0);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    check("stray_set", stray_gnt, 1);
    check("stray_no_busy", busy, 0);
    tick(); tick();
    check("stray_sticky", stray_gnt, 1);
    run_txn(1, 2, 1);
    check("stray_sticky2", stray_gnt, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #3 reset = 1'b1;
    #1;
    check("arst_req", req, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_attempt", attempt, 0);
    check("arst_cnt", grant_cnt, 0);
    #10 reset = 1'b0;
    exp_cnt = 0;
    tick();
    check("post_rst_done", done, 0);
    check("post_rst_err", err, 0);
    run_txn(1, 3, 0);
    for (int i = 0; i < 256; i++) run_txn(1, 1, 0);
    check("cnt_saturated", grant_cnt, 255);
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/req_initiator.md
Name: req_initiator

Overview:
- Initiator side of the single-bit req/gnt handshake: the block that drives `req` and waits for `gnt` from the granting block.
- A local user pulses `start`. The block raises `req` and holds it until `gnt` is sampled or a timeout expires.
- After a timeout it backs off and retries a bounded number of times, then reports done or error.
- Sits in front of any req/gnt responder in the design; also serves as the reusable stimulus source for handshake benches.

Parameters:
- TIMEOUT, 4: max cycles `req` stays high per attempt waiting for `gnt` (range 1..255).
- BACKOFF, 2: idle cycles with `req` low between a timeout and the next attempt (range 1..255).
- MAX_RETRY, 3: total attempts per transaction before `err` (range 1..15).
- CNT_W, 8: width of the `grant_cnt` statistics counter.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle request to begin a transaction; ignored while `busy`=1.
- gnt, input, 1: grant from the responder, sampled at posedge `clk`.
- req, output, 1: request to the responder, registered.
- busy, output, 1: high from the cycle after `start` is accepted until the cycle after `done`/`err`.
- done, output, 1: one-cycle pulse when a grant was received.
- err, output, 1: one-cycle pulse when all attempts timed out.
- attempt, output, 4: attempt number of the current or last transaction, 1-based; 0 after reset.
- grant_cnt, output, CNT_W: saturating count of successful transactions.
- stray_gnt, output, 1: sticky flag; set when `gnt`=1 is sampled while `req`=0.

Behaviour:
- Reset (asynchronous, any state): state IDLE; `req`, `busy`, `done`, `err`, `stray_gnt` = 0; `attempt` = 0; `grant_cnt` = 0; wait/backoff counters = 0. Reset mid-transaction drops `req` immediately; no `done`/`err` is produced.
- All outputs are registered. There is no combinational path from `gnt` or `start` to any output.
- States and transitions:
  - IDLE: `req`=0, `busy`=0. `start`=1 at posedge → REQ; `attempt` := 1, `wait_cnt` := 0, `req`=1 and `busy`=1 from that edge.
  - REQ: `req`=1.
    - `gnt`=1 at posedge → DONE.
    - `gnt`=0 and `wait_cnt`==TIMEOUT-1 → timeout.
    - Otherwise `wait_cnt`++.
    - Net effect: `req` is high for at most TIMEOUT consecutive cycles per attempt.
  - Timeout handling:
    - If `attempt`==MAX_RETRY → ERR.
    - Else → BACKOFF; `req`=0, `bo_cnt` := 0.
  - BACKOFF: `req`=0 for exactly BACKOFF cycles. Then → REQ; `attempt`++, `wait_cnt` := 0.
  - DONE: one cycle. `req`=0, `done`=1; `grant_cnt`++ (saturates at all-ones). Next cycle → IDLE, `busy`=0.
  - ERR: one cycle. `req`=0, `err`=1. Next cycle → IDLE, `busy`=0.
- Grant latency is the count of posedges from `req` rising to `gnt` sampled high, in the range 1..TIMEOUT. `req` falls on the edge following the sampled grant.
- `gnt` on the same edge as the timeout boundary (`wait_cnt`==TIMEOUT-1): the grant wins → DONE.
- `gnt` sampled in IDLE, BACKOFF, DONE or ERR: ignored for the FSM; sets `stray_gnt`. `stray_gnt` clears only on reset.
- `start` while `busy`=1: ignored, no queuing. `start` on the same cycle `done`/`err` is asserted is also ignored, because `busy` is still 1.
- `attempt` holds its final value in IDLE until the next accepted `start`.

Optional Feature:
- Macro REQ_INITIATOR_ASSERT_EN.
- When defined, the block contains concurrent SVA properties clocked on posedge `clk`, disabled iff `reset`:
  - `req` rising implies `req` stays high until `gnt` or TIMEOUT cycles elapse.
  - `done` and `err` are never high together.
  - `done` or `err` is always preceded by `busy`.
  - `req`=0 while `busy`=0.
  - A cover property counts grants at latency 1 and at latency TIMEOUT.
- When undefined, no assertion code is compiled. Functional behaviour is identical either way.

Test Plan:
- Reset 20 ns, then `start` pulse with the responder granting 2 cycles after `req` rises → `req` high 2 cycles, `done` pulse on the following cycle, `attempt`=1, `grant_cnt`=1, `busy` low the cycle after `done`.
- `start` with `gnt` held 0 (defaults) → three `req` pulses of 4 cycles each, separated by 2-cycle gaps; `err` pulse after the 3rd; `attempt`=3; `grant_cnt` unchanged.
- `gnt` first asserted on the 4th `req` cycle of attempt 2 → `done`, `attempt`=2, `err` never asserted.
- `gnt` pulsed while IDLE, plus a second `start` issued during REQ → `stray_gnt`=1 sticky; second `start` ignored (only one `done`).
- `reset` asserted asynchronously mid-REQ (between clock edges) → `req`, `busy` drop immediately; no `done`/`err`; a fresh `start` after release works normally with `attempt`=1.
- 255+ successful transactions with CNT_W=8 → `grant_cnt` saturates at 255 and stays there.
